hm_sched: RTL and testbench

HM_SCHED -- requirements
Module: hm_sched

---
 rtl/hm_sched_pkg.sv | 33 +++
 rtl/hm_rr_pick.sv | 57 +++++
 rtl/hm_sched.sv | 197 +++++++++++++++++++
 tb/tb_hm_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hm_sched_pkg.sv
// ---------------------------------------------------------------------------
// hm_sched_pkg
// Shared definitions for the page-read scheduler:
//   - hm_state_t       : scheduler state encoding (IDLE/START/WAIT/HOLDOFF)
//   - default MAX_RETRY and WDOG_CYCLES values
//   - common widths (address, owner index, watchdog, statistics)
//   - hm_sat_inc       : saturating increment for the retry statistic
// ---------------------------------------------------------------------------
package hm_sched_pkg;

    typedef enum logic [1:0] {
        HM_SCHED_IDLE    = 2'd0,
        HM_SCHED_START   = 2'd1,
        HM_SCHED_WAIT    = 2'd2,
        HM_SCHED_HOLDOFF = 2'd3
    } hm_state_t;

    localparam int HM_MAX_RETRY_DEFAULT   = 3;
    localparam int HM_WDOG_CYCLES_DEFAULT = 65535;

    localparam int HM_ADDR_W  = 64;
    // Owner/grant index width; also bounds the requester count to 8.
    localparam int HM_IDX_W   = 3;
    localparam int HM_IDX_N   = 8;
    localparam int HM_WDOG_W  = 16;
    localparam int HM_STAT_W  = 8;
    localparam int HM_RETRY_W = 8;

    function automatic logic [HM_STAT_W-1:0] hm_sat_inc(input logic [HM_STAT_W-1:0] v);
        return (v == {HM_STAT_W{1'b1}}) ? v : v + HM_STAT_W'(1);
    endfunction

endpackage

// File: rtl/hm_rr_pick.sv
// ---------------------------------------------------------------------------
// hm_rr_pick
// Combinational round-robin selector. Searches req_valid starting at
// (last_grant + 1) mod NREQ, upward with wrap, and returns the first
// requester found.
// Ports:
//   req_valid  in  NREQ  pending requests
//   last_grant in  3     index of the most recently served requester
//   winner     out 3     selected requester index (0 when none)
//   win_valid  out 1     at least one request is pending
// ---------------------------------------------------------------------------
module hm_rr_pick
    import hm_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]     req_valid,
    input  logic [HM_IDX_W-1:0] last_grant,
    output logic [HM_IDX_W-1:0] winner,
    output logic                win_valid
);

    localparam int SUM_W = HM_IDX_W + 1;

    // Padded to the full index range so a 3-bit index selects exactly.
    logic [HM_IDX_N-1:0] req_pad;
    logic [HM_IDX_W-1:0] cand_idx [NREQ];
    logic [NREQ-1:0]     cand_hit;

    assign req_pad = HM_IDX_N'(req_valid);

    // Candidate gi is the requester gi+1 places after last_grant. Since
    // last_grant < NREQ and gi+1 <= NREQ, one conditional subtract is a
    // complete modulo.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [SUM_W-1:0] sum;
            assign sum = {1'b0, last_grant} + SUM_W'(gi + 1);
            assign cand_idx[gi] = (sum >= SUM_W'(NREQ)) ? HM_IDX_W'(sum - SUM_W'(NREQ))
                                                        : sum[HM_IDX_W-1:0];
            assign cand_hit[gi] = req_pad[cand_idx[gi]];
        end
    endgenerate

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner    = cand_idx[k];
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hm_sched.sv
// ---------------------------------------------------------------------------
// hm_sched
// Arbitrates page-read requests from NREQ requesters onto a single page
// reader, with round-robin fairness, timeout retries and a local watchdog.
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   en                 gates new grants only
//   req_valid/req_addr requester handshake (addr i at bits [64i+63:64i])
//   req_ready          one-cycle accept pulse to the granted requester
//   rsp_done/rsp_err   one-cycle completion / failure pulse per requester
//   hm_start           one-cycle start pulse to the page reader
//   hm_page_addr       page address, stable from grant to completion
//   hm_end             page-reader completion pulse
//   hm_timeout         page-reader timeout (level)
//   hm_error           page-reader error / link down (level)
//   busy               any state other than IDLE
//   owner              current or last granted requester
//   stat_retry         saturating retry count since reset
// ---------------------------------------------------------------------------
module hm_sched
    import hm_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int MAX_RETRY   = HM_MAX_RETRY_DEFAULT,
    parameter int WDOG_CYCLES = HM_WDOG_CYCLES_DEFAULT
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      en,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*HM_ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_done,
    output logic [NREQ-1:0]           rsp_err,
    output logic                      hm_start,
    output logic [HM_ADDR_W-1:0]      hm_page_addr,
    input  logic                      hm_end,
    input  logic                      hm_timeout,
    input  logic                      hm_error,
    output logic                      busy,
    output logic [HM_IDX_W-1:0]       owner,
    output logic [HM_STAT_W-1:0]      stat_retry
);

    localparam logic [NREQ-1:0]       ONE_HOT     = NREQ'(1);
    localparam logic [HM_RETRY_W-1:0] RETRY_LIMIT = HM_RETRY_W'(MAX_RETRY);
    localparam logic [HM_WDOG_W:0]    WDOG_LIMIT  = (HM_WDOG_W + 1)'(WDOG_CYCLES);

    hm_state_t              state_reg,      state_next;
    logic [HM_IDX_W-1:0]    last_grant_reg, last_grant_next;
    logic [HM_IDX_W-1:0]    owner_reg,      owner_next;
    logic [HM_ADDR_W-1:0]   addr_reg,       addr_next;
    logic [HM_RETRY_W-1:0]  retry_reg,      retry_next;
    logic [HM_STAT_W-1:0]   stat_reg,       stat_next;
    logic [HM_WDOG_W-1:0]   wdog_reg,       wdog_next;
    logic [NREQ-1:0]        req_ready_reg,  req_ready_next;
    logic [NREQ-1:0]        rsp_done_reg,   rsp_done_next;
    logic [NREQ-1:0]        rsp_err_reg,    rsp_err_next;
    logic                   hm_start_reg,   hm_start_next;

    logic [HM_IDX_W-1:0]    winner;
    logic                   win_valid;
    logic                   wdog_hit;
    logic [HM_ADDR_W-1:0]   addr_table [HM_IDX_N];

    hm_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_reg),
        .winner     (winner),
        .win_valid  (win_valid)
    );

    // Address slices padded to the full index range; unused slots read zero.
    generate
        for (genvar gi = 0; gi < HM_IDX_N; gi++) begin : g_addr
            if (gi < NREQ) begin : g_used
                assign addr_table[gi] = req_addr[HM_ADDR_W*gi +: HM_ADDR_W];
            end else begin : g_pad
                assign addr_table[gi] = '0;
            end
        end
    endgenerate

    // The watchdog expires on the WAIT cycle whose increment would reach
    // WDOG_CYCLES, i.e. after WDOG_CYCLES cycles spent in WAIT.
    assign wdog_hit = ({1'b0, wdog_reg} + (HM_WDOG_W + 1)'(1)) >= WDOG_LIMIT;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        owner_next      = owner_reg;
        addr_next       = addr_reg;
        retry_next      = retry_reg;
        stat_next       = stat_reg;
        wdog_next       = wdog_reg;
        req_ready_next  = '0;
        rsp_done_next   = '0;
        rsp_err_next    = '0;
        hm_start_next   = 1'b0;

        unique case (state_reg)
            HM_SCHED_IDLE: begin
                // A downed link blocks grants; requests simply stay pending.
                if (en && !hm_error && win_valid) begin
                    req_ready_next = ONE_HOT << winner;
                    addr_next      = addr_table[winner];
                    owner_next     = winner;
                    retry_next     = '0;
                    wdog_next      = '0;
                    state_next     = HM_SCHED_START;
                end
            end

            HM_SCHED_START: begin
                hm_start_next = 1'b1;
                state_next    = HM_SCHED_WAIT;
            end

            HM_SCHED_WAIT: begin
                wdog_next = wdog_reg + HM_WDOG_W'(1);
                if (hm_end) begin
                    rsp_done_next   = ONE_HOT << owner_reg;
                    last_grant_next = owner_reg;
                    state_next      = HM_SCHED_IDLE;
                end else if (hm_error) begin
                    rsp_err_next    = ONE_HOT << owner_reg;
                    last_grant_next = owner_reg;
                    state_next      = HM_SCHED_IDLE;
                end else if (hm_timeout || wdog_hit) begin
                    if (retry_reg < RETRY_LIMIT) begin
                        retry_next = retry_reg + HM_RETRY_W'(1);
                        stat_next  = hm_sat_inc(stat_reg);
                        state_next = HM_SCHED_HOLDOFF;
                    end else begin
                        // Failed requesters still advance the pointer so
                        // they cannot monopolise the reader.
                        rsp_err_next    = ONE_HOT << owner_reg;
                        last_grant_next = owner_reg;
                        state_next      = HM_SCHED_IDLE;
                    end
                end
            end

            HM_SCHED_HOLDOFF: begin
                // Re-issue only once the reader has dropped its timeout.
                if (!hm_timeout) begin
                    wdog_next  = '0;
                    state_next = HM_SCHED_START;
                end
            end

            default: begin
                state_next = HM_SCHED_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg      <= HM_SCHED_IDLE;
            last_grant_reg <= HM_IDX_W'(NREQ - 1);
            owner_reg      <= '0;
            addr_reg       <= '0;
            retry_reg      <= '0;
            stat_reg       <= '0;
            wdog_reg       <= '0;
            req_ready_reg  <= '0;
            rsp_done_reg   <= '0;
            rsp_err_reg    <= '0;
            hm_start_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            owner_reg      <= owner_next;
            addr_reg       <= addr_next;
            retry_reg      <= retry_next;
            stat_reg       <= stat_next;
            wdog_reg       <= wdog_next;
            req_ready_reg  <= req_ready_next;
            rsp_done_reg   <= rsp_done_next;
            rsp_err_reg    <= rsp_err_next;
            hm_start_reg   <= hm_start_next;
        end
    end

    assign req_ready    = req_ready_reg;
    assign rsp_done     = rsp_done_reg;
    assign rsp_err      = rsp_err_reg;
    assign hm_start     = hm_start_reg;
    assign hm_page_addr = addr_reg;
    assign owner        = owner_reg;
    assign stat_retry   = stat_reg;
    assign busy         = (state_reg != HM_SCHED_IDLE);

endmodule

// File: tb/tb_hm_sched.sv
// ---------------------------------------------------------------------------
// tb_hm_sched
// Self-checking bench for hm_sched. A transaction-level model tracks the
// pending set, the round-robin pointer, the retry budget and the retry
// statistic; a scripted page reader answers each attempt with end, error,
// timeout, silence (watchdog) or end+timeout together.
// ---------------------------------------------------------------------------
module tb_hm_sched;

    localparam int NREQ      = 4;
    localparam int MAX_RETRY = 3;
    localparam int WDOG      = 16;

    localparam int K_END    = 0;
    localparam int K_ERR    = 1;
    localparam int K_TO     = 2;
    localparam int K_WDOG   = 3;
    localparam int K_END_TO = 4;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst = 1'b1;
    logic                 en = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*64-1:0]   req_addr;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_done;
    logic [NREQ-1:0]      rsp_err;
    logic                 hm_start;
    logic [63:0]          hm_page_addr;
    logic                 hm_end = 1'b0;
    logic                 hm_timeout = 1'b0;
    logic                 hm_error = 1'b0;
    logic                 busy;
    logic [2:0]           owner;
    logic [7:0]           stat_retry;

    int          checks   = 0;
    int          failures = 0;
    int          txn_no   = 0;
    int          m_last;
    int          m_stat;
    logic [63:0] m_addr [NREQ];
    int          script_kind [8];
    int          script_len;
    bit          drop_en_mid = 1'b0;
    bit          prev_start  = 1'b0;

    always #5 sys_clk = ~sys_clk;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
            assign req_addr[64*gi +: 64] = m_addr[gi];
        end
    endgenerate

    hm_sched #(
        .NREQ        (NREQ),
        .MAX_RETRY   (MAX_RETRY),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .en           (en),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_done     (rsp_done),
        .rsp_err      (rsp_err),
        .hm_start     (hm_start),
        .hm_page_addr (hm_page_addr),
        .hm_end       (hm_end),
        .hm_timeout   (hm_timeout),
        .hm_error     (hm_error),
        .busy         (busy),
        .owner        (owner),
        .stat_retry   (stat_retry)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check per-cycle invariants.
    task automatic tick();
        @(negedge sys_clk);
        chk("pulse_onehot", 64'($countones({req_ready, rsp_done, rsp_err}) <= 1), 1);
        chk("start_1cycle", 64'(prev_start & hm_start), 0);
        prev_start = hm_start;
    endtask

    function automatic int model_pick();
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic raise_req(input int i, input logic [63:0] a);
        m_addr[i]    = a;
        req_valid[i] = 1'b1;
    endtask

    task automatic set_script1(input int k0);
        script_kind[0] = k0;
        script_len     = 1;
    endtask

    task automatic gen_script();
        int f;
        f = $urandom_range(0, 4);
        script_len = 0;
        for (int i = 0; i < f; i++) begin
            script_kind[script_len] = ($urandom_range(0, 5) == 0) ? K_WDOG : K_TO;
            script_len++;
        end
        case ($urandom_range(0, 3))
            0, 1:    script_kind[script_len] = K_END;
            2:       script_kind[script_len] = K_END_TO;
            default: script_kind[script_len] = K_ERR;
        endcase
        script_len++;
    endtask

    // One full grant-to-response transaction driven by the current script.
    task automatic run_txn(output int granted);
        int w, n, retries, s, kind, d;
        bit fin;
        logic [NREQ-1:0] oh;
        string res;
        w = model_pick();
        granted = w;
        if (w < 0) begin
            $display("FAIL stimulus: no pending request");
            $fatal(1, "bench stimulus error");
        end
        oh = '0;
        oh[w] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (req_ready == '0 && n < 8);
        chk("req_ready", 64'(req_ready), 64'(oh));
        chk("owner", 64'(owner), 64'(w));
        req_valid = req_valid & ~oh;
        n = 0;
        do begin tick(); n++; end while (!hm_start && n < 8);
        chk("hm_start", 64'(hm_start), 1);
        chk("page_addr", hm_page_addr, m_addr[w]);
        chk("busy_wait", 64'(busy), 1);
        if (drop_en_mid) en = 1'b0;
        retries = 0;
        fin = 1'b0;
        s = 0;
        res = "done";
        while (!fin) begin
            kind = (s < script_len) ? script_kind[s] : K_END;
            s++;
            case (kind)
                K_END, K_END_TO: begin
                    d = (kind == K_END) ? $urandom_range(0, 3) : 0;
                    repeat (d) tick();
                    hm_end = 1'b1;
                    if (kind == K_END_TO) hm_timeout = 1'b1;
                    tick();
                    hm_end = 1'b0;
                    hm_timeout = 1'b0;
                    chk("rsp_done", 64'(rsp_done), 64'(oh));
                    chk("rsp_err_ok", 64'(rsp_err), 0);
                    fin = 1'b1;
                end
                K_ERR: begin
                    repeat ($urandom_range(0, 3)) tick();
                    hm_error = 1'b1;
                    tick();
                    hm_error = 1'b0;
                    chk("rsp_err", 64'(rsp_err), 64'(oh));
                    chk("rsp_done_err", 64'(rsp_done), 0);
                    res = "err";
                    fin = 1'b1;
                end
                K_TO: begin
                    hm_timeout = 1'b1;
                    tick();
                    if (retries == MAX_RETRY) begin
                        hm_timeout = 1'b0;
                        chk("rsp_err_exh", 64'(rsp_err), 64'(oh));
                        chk("rsp_done_exh", 64'(rsp_done), 0);
                        res = "err";
                        fin = 1'b1;
                    end else begin
                        retries++;
                        m_stat = (m_stat < 255) ? m_stat + 1 : 255;
                        chk("rsp_err_to", 64'(rsp_err), 0);
                        chk("stat_retry", 64'(stat_retry), 64'(m_stat));
                        repeat ($urandom_range(0, 2)) tick();
                        hm_timeout = 1'b0;
                        n = 0;
                        do begin tick(); n++; end while (!hm_start && n < 8);
                        chk("hm_restart", 64'(hm_start), 1);
                        chk("page_addr_retry", hm_page_addr, m_addr[w]);
                    end
                end
                default: begin
                    // Silent reader: the watchdog fires after WDOG cycles in
                    // WAIT; a retry adds one HOLDOFF and one START cycle.
                    n = 0;
                    do begin tick(); n++; end while (!hm_start && rsp_err == '0 && n < 4 * WDOG);
                    if (retries == MAX_RETRY) begin
                        chk("wdog_err", 64'(rsp_err), 64'(oh));
                        chk("wdog_err_time", 64'(n), 64'(WDOG));
                        res = "err";
                        fin = 1'b1;
                    end else begin
                        retries++;
                        m_stat = (m_stat < 255) ? m_stat + 1 : 255;
                        chk("wdog_restart", 64'(hm_start), 1);
                        chk("wdog_time", 64'(n), 64'(WDOG + 2));
                        chk("stat_retry_wd", 64'(stat_retry), 64'(m_stat));
                    end
                end
            endcase
        end
        m_last = w;
        chk("idle_after", 64'(busy), 0);
        chk("stat_final", 64'(stat_retry), 64'(m_stat));
        $display("txn %0d: req %0d addr 0x%016h retries %0d result %s",
                 txn_no, w, m_addr[w], retries, res);
        txn_no++;
    endtask

    int g;
    int n;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int i = 0; i < NREQ; i++) m_addr[i] = '0;
        m_last = NREQ - 1;
        m_stat = 0;

        // Reset values
        repeat (3) tick();
        sys_rst = 1'b0;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_done", 64'(rsp_done), 0);
        chk("rst_err", 64'(rsp_err), 0);
        chk("rst_start", 64'(hm_start), 0);
        chk("rst_owner", 64'(owner), 0);
        chk("rst_addr", hm_page_addr, 0);
        chk("rst_stat", 64'(stat_retry), 0);
        en = 1'b1;

        // Fairness with all four requesters kept pending
        for (int i = 0; i < NREQ; i++) raise_req(i, 64'h1_0000 * (i + 1));
        set_script1(K_END);
        for (int i = 0; i < 5; i++) begin
            run_txn(g);
            chk("fair_order", 64'(owner), 64'(order[i]));
            req_valid[g] = 1'b1;
        end
        req_valid = '0;

        // Single request
        raise_req(0, 64'h1000);
        run_txn(g);
        chk("single_addr", hm_page_addr, 64'h1000);

        // Three timeouts then success
        raise_req(2, 64'hDEAD_BEEF_0000_2000);
        script_kind[0] = K_TO; script_kind[1] = K_TO; script_kind[2] = K_TO;
        script_kind[3] = K_END; script_len = 4;
        run_txn(g);
        chk("stat_eq3", 64'(stat_retry), 3);

        // Exhaustion, then the other pending requester is served
        raise_req(1, 64'h1111_0000);
        raise_req(3, 64'h3333_0000);
        for (int i = 0; i < 4; i++) script_kind[i] = K_TO;
        script_len = 4;
        run_txn(g);
        chk("exh_owner", 64'(owner), 3);
        set_script1(K_END);
        run_txn(g);
        chk("next_owner", 64'(owner), 1);

        // Simultaneous end and timeout, then watchdog retry
        raise_req(0, 64'hABCD);
        set_script1(K_END_TO);
        run_txn(g);
        raise_req(2, 64'h2222);
        script_kind[0] = K_WDOG; script_kind[1] = K_END; script_len = 2;
        run_txn(g);

        // Link down in IDLE blocks grants
        raise_req(3, 64'h3030);
        hm_error = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_idle_ready", 64'(req_ready), 0);
            chk("err_idle_busy", 64'(busy), 0);
        end
        hm_error = 1'b0;
        set_script1(K_END);
        run_txn(g);

        // en low blocks grants; en falling mid-request lets it finish
        en = 1'b0;
        raise_req(1, 64'h1010);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en0_ready", 64'(req_ready), 0);
        end
        en = 1'b1;
        raise_req(0, 64'h0F0F);
        drop_en_mid = 1'b1;
        set_script1(K_END);
        run_txn(g);
        drop_en_mid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_drop_ready", 64'(req_ready), 0);
            chk("en_drop_busy", 64'(busy), 0);
        end
        en = 1'b1;
        run_txn(g);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    raise_req(i, {$urandom, $urandom});
            end
            if (req_valid == '0) raise_req(0, {$urandom, $urandom});
            gen_script();
            run_txn(g);
        end
        req_valid = '0;

        // Reset while waiting for the reader
        raise_req(1, 64'h5555_AAAA);
        n = 0;
        do begin tick(); n++; end while (req_ready == '0 && n < 8);
        req_valid = '0;
        n = 0;
        do begin tick(); n++; end while (!hm_start && n < 8);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        m_last = NREQ - 1;
        m_stat = 0;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_owner", 64'(owner), 0);
        chk("mid_rst_addr", hm_page_addr, 0);
        chk("mid_rst_stat", 64'(stat_retry), 0);
        chk("mid_rst_start", 64'(hm_start), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_done", 64'(rsp_done), 0);
            chk("mid_rst_err", 64'(rsp_err), 0);
            chk("mid_rst_ready", 64'(req_ready), 0);
        end
        raise_req(1, 64'h7777);
        raise_req(0, 64'h6666);
        set_script1(K_END);
        run_txn(g);
        chk("post_rst_owner", 64'(owner), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
